// File: rtl/ddr2pe_unpool.sv
// ddr2pe_unpool: gradient/mask DDR loader scattering beats into four PE buffer groups, with optional 2x2 max-unpool.
// Optional DDR2PE_UNPOOL_SCALE_EN adds a saturating left shift by conf_shift in stage 1.
module ddr2pe_unpool #(
  parameter int BATCH = 8,
  parameter int DATA_W = 16,
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W = $clog2(BUF_DEPTH),
  localparam int DDR_W = BATCH * DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 done,
  input  logic                 conf_pooling,
  input  logic                 conf_mask_en,
  input  logic [3:0]           conf_ch_num,
  input  logic [3:0]           conf_pix_num,
  input  logic [3:0]           conf_row_num,
  input  logic [3:0]           conf_shift,
  input  logic [DDR_W-1:0]     ddr1_data,
  input  logic                 ddr1_valid,
  output logic                 ddr1_ready,
  input  logic [DDR_W-1:0]     ddr2_data,
  input  logic                 ddr2_valid,
  output logic                 ddr2_ready,
  output logic [ADDR_W-1:0]    buf_wr_addr,
  output logic [4*DDR_W-1:0]   buf_wr_data,
  output logic [3:0]           buf_wr_en
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [3:0] ch_q, ch_d, pix_q, pix_d, row_q, row_d;
  logic mask_used, accept, clr, ch_last, pix_last, row_last, last;
  logic s1_v_q;
  logic [DDR_W-1:0] s1_grad_q, s1_grad_d;
  logic [4*BATCH-1:0] s1_mask_q, s1_mask_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [1:0] s1_grp_q, s1_grp_d;
  logic [3:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [4*DDR_W-1:0] wr_data_q, wr_data_d;
  logic unused_bits;
`ifdef DDR2PE_UNPOOL_SCALE_EN
  localparam logic signed [DATA_W+15:0] SAT_MAX = {{17{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+15:0] SAT_MIN = {{17{1'b1}}, {(DATA_W-1){1'b0}}};
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] g, input logic [3:0] sh);
    logic signed [DATA_W+15:0] w;
    w = $signed({{16{g[DATA_W-1]}}, g}) <<< sh;
    return (w > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : (w < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : w[DATA_W-1:0];
  endfunction
`endif
  assign unused_bits = ^{conf_shift, ddr2_data};
  assign done = state_q == IDLE;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign buf_wr_en = wr_en_q;
  always_comb begin
    mask_used = conf_pooling | conf_mask_en;
    ddr1_ready = (state_q == RUN) && (!mask_used || ddr2_valid);
    ddr2_ready = (state_q == RUN) && mask_used && ddr1_valid;
    accept = ddr1_valid && ddr1_ready;
    clr = (state_q == IDLE) && start;
    ch_last = ch_q == conf_ch_num;
    pix_last = pix_q == conf_pix_num;
    row_last = row_q == conf_row_num;
    last = accept && ch_last && pix_last && row_last;
    state_d = clr ? RUN : (state_q == RUN && last) ? DRAIN : (state_q == DRAIN && !s1_v_q) ? IDLE : state_q;
    ch_d = clr ? 4'd0 : accept ? (ch_last ? 4'd0 : ch_q + 4'd1) : ch_q;
    pix_d = clr ? 4'd0 : (accept && ch_last) ? (pix_last ? 4'd0 : pix_q + 4'd1) : pix_q;
    row_d = clr ? 4'd0 : (accept && ch_last && pix_last) ? (row_last ? 4'd0 : row_q + 4'd1) : row_q;
    s1_addr_d = '0;
    s1_addr_d[ADDR_W-1 -: 4] = ch_q;
    s1_addr_d[3] = conf_pooling ? row_q[0] : row_q[1];
    s1_addr_d[2:0] = conf_pooling ? pix_q[2:0] : pix_q[3:1];
    s1_grp_d = {row_q[0], pix_q[0]};
    s1_grad_d = '0;
    s1_mask_d = '0;
    // Without a mask stream every lane behaves as fully enabled
    for (int i = 0; i < BATCH; i++) begin
`ifdef DDR2PE_UNPOOL_SCALE_EN
      s1_grad_d[i*DATA_W +: DATA_W] = scale(ddr1_data[i*DATA_W +: DATA_W], conf_shift);
`else
      s1_grad_d[i*DATA_W +: DATA_W] = ddr1_data[i*DATA_W +: DATA_W];
`endif
      s1_mask_d[i*4 +: 4] = mask_used ? ddr2_data[i*DATA_W +: 4] : 4'hF;
    end
  end
  always_comb begin
    wr_data_d = '0;
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < BATCH; i++)
        wr_data_d[g*DDR_W + i*DATA_W +: DATA_W] =
          (conf_pooling ? s1_mask_q[i*4 + g] : |s1_mask_q[i*4 +: 4]) ? s1_grad_q[i*DATA_W +: DATA_W] : '0;
    wr_en_d = !s1_v_q ? 4'd0 : conf_pooling ? 4'hF : 4'd1 << s1_grp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      pix_q <= '0;
      row_q <= '0;
      s1_v_q <= 1'b0;
      s1_grad_q <= '0;
      s1_mask_q <= '0;
      s1_addr_q <= '0;
      s1_grp_q <= '0;
      wr_en_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      pix_q <= pix_d;
      row_q <= row_d;
      s1_v_q <= accept;
      if (accept) begin
        s1_grad_q <= s1_grad_d;
        s1_mask_q <= s1_mask_d;
        s1_addr_q <= s1_addr_d;
        s1_grp_q <= s1_grp_d;
      end
      wr_en_q <= wr_en_d;
      if (s1_v_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= wr_data_d;
      end
    end
  end
endmodule

// File: tb/tb_ddr2pe_unpool.sv
// tb_ddr2pe_unpool: randomized scoreboard bench for ddr2pe_unpool against a beat-index reference model.
module tb_ddr2pe_unpool;
  localparam int BATCH = 8;
  localparam int DATA_W = 16;
  localparam int DDR_W = BATCH * DATA_W;
  localparam int ADDR_W = 8;
  localparam int WD = 4 * DDR_W;
  typedef struct {
    logic [3:0] en;
    logic [ADDR_W-1:0] addr;
    logic [WD-1:0] data;
  } wr_t;
  logic clk = 0, rst = 1, start = 0;
  logic done;
  logic conf_pooling = 0, conf_mask_en = 0;
  logic [3:0] conf_ch_num = 0, conf_pix_num = 0, conf_row_num = 0, conf_shift = 0;
  logic [DDR_W-1:0] ddr1_data = '0, ddr2_data = '0;
  logic ddr1_valid = 0, ddr2_valid = 0;
  logic ddr1_ready, ddr2_ready;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [WD-1:0] buf_wr_data;
  logic [3:0] buf_wr_en;
  wr_t exp_q[$];
  int n_checks = 0, n_pass = 0;
  always #5 clk = ~clk;
  ddr2pe_unpool dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .conf_pooling(conf_pooling), .conf_mask_en(conf_mask_en),
    .conf_ch_num(conf_ch_num), .conf_pix_num(conf_pix_num), .conf_row_num(conf_row_num),
    .conf_shift(conf_shift),
    .ddr1_data(ddr1_data), .ddr1_valid(ddr1_valid), .ddr1_ready(ddr1_ready),
    .ddr2_data(ddr2_data), .ddr2_valid(ddr2_valid), .ddr2_ready(ddr2_ready),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .buf_wr_en(buf_wr_en)
  );
  task automatic chk(input string name, input logic [WD-1:0] got, input logic [WD-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask
  function automatic logic [DATA_W-1:0] sc(input logic [DATA_W-1:0] g);
`ifdef DDR2PE_UNPOOL_SCALE_EN
    longint v;
    v = longint'($signed(g)) * (longint'(1) << conf_shift);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[DATA_W-1:0];
`else
    return g;
`endif
  endfunction
  // Reference: beat k of a pass maps to (ch, pix, row) with ch innermost
  function automatic wr_t model(input int k, input logic [DDR_W-1:0] g, input logic [DDR_W-1:0] m);
    wr_t w;
    int ch, pix, row, grp;
    bit mu;
    logic [3:0] mk;
    logic [DATA_W-1:0] gv;
    mu = conf_pooling || conf_mask_en;
    ch = k % (conf_ch_num + 1);
    pix = (k / (conf_ch_num + 1)) % (conf_pix_num + 1);
    row = k / ((conf_ch_num + 1) * (conf_pix_num + 1));
    grp = (row % 2) * 2 + (pix % 2);
    w.addr = ADDR_W'(ch * 16 + (conf_pooling ? (row % 2) * 8 + pix % 8 : ((row / 2) % 2) * 8 + pix / 2));
    w.en = conf_pooling ? 4'hF : 4'(1 << grp);
    w.data = '0;
    for (int i = 0; i < BATCH; i++) begin
      mk = m[i*DATA_W +: 4];
      gv = sc(g[i*DATA_W +: DATA_W]);
      for (int q = 0; q < 4; q++)
        if (conf_pooling) w.data[q*DDR_W + i*DATA_W +: DATA_W] = mk[q] ? gv : '0;
        else if (q == grp) w.data[q*DDR_W + i*DATA_W +: DATA_W] = (!mu || mk != 0) ? gv : '0;
    end
    return w;
  endfunction
  initial begin : monitor
    wr_t w;
    logic [WD-1:0] dm;
    forever begin
      @(negedge clk);
      if (!rst && buf_wr_en != 0) begin
        if (exp_q.size() == 0) chk("unexpected_write", WD'(buf_wr_en), '0);
        else begin
          w = exp_q.pop_front();
          dm = '0;
          for (int q = 0; q < 4; q++) if (w.en[q]) dm[q*DDR_W +: DDR_W] = '1;
          chk("wr_en", WD'(buf_wr_en), WD'(w.en));
          chk("wr_addr", WD'(buf_wr_addr), WD'(w.addr));
          chk("wr_data", buf_wr_data & dm, w.data);
        end
      end
    end
  end
  function automatic logic [DDR_W-1:0] rnd_beat(input bit mask);
    logic [DDR_W-1:0] b;
    for (int i = 0; i < BATCH; i++) begin
      b[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      if (mask && $urandom_range(0, 3) == 0) b[i*DATA_W +: 4] = 4'h0;
    end
    return b;
  endfunction
  // mode 0: always valid; 1: ddr2_valid toggles; 2: both random
  task automatic run_pass(input logic pool, input logic men, input logic [3:0] c, input logic [3:0] p,
                          input logic [3:0] r, input int mode, input int stop_after, input bit directed);
    int total, k, cyc;
    bit have, mu;
    logic [DDR_W-1:0] g, m;
    conf_pooling = pool; conf_mask_en = men;
    conf_ch_num = c; conf_pix_num = p; conf_row_num = r;
    total = (c + 1) * (p + 1) * (r + 1);
    mu = pool || men;
    k = 0; cyc = 0; have = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("done_fall", WD'(done), '0);
    while (k < total && k < stop_after && cyc < 2000) begin
      if (!have) begin
        g = rnd_beat(0);
        m = rnd_beat(1);
        if (directed && k == 0) begin
          g[0 +: DATA_W] = 16'h0123; m[0 +: 4] = 4'b0100;
          m[DATA_W +: 4] = 4'h0;
          g[3*DATA_W +: DATA_W] = 16'hFFFB; m[3*DATA_W +: 4] = 4'h0;
        end
        have = 1;
      end
      ddr1_data = g; ddr2_data = m;
      ddr1_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr2_valid = (mode == 1) ? 1'(cyc % 2) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("ddr1_ready", WD'(ddr1_ready), WD'(mu ? ddr2_valid : 1'b1));
      chk("ddr2_ready", WD'(ddr2_ready), WD'(mu && ddr1_valid));
      if (ddr1_valid && ddr1_ready) begin
        exp_q.push_back(model(k, g, m));
        k++;
        have = 0;
      end
      @(negedge clk);
      cyc++;
    end
    ddr1_valid = 0; ddr2_valid = 0;
    if (cyc >= 2000) chk("pass_timeout", WD'(k), WD'(total));
    else if (k == stop_after && k < total) begin
      rst = 1;
      void'(exp_q.pop_back());
      ddr1_valid = 1; ddr2_valid = 1;
      @(negedge clk);
      chk("rst_wr_en", WD'(buf_wr_en), '0);
      chk("rst_done", WD'(done), WD'(1));
      chk("rst_readies", WD'({ddr1_ready, ddr2_ready}), '0);
      chk("rst_flush", WD'(exp_q.size()), '0);
      rst = 0; ddr1_valid = 0; ddr2_valid = 0;
      exp_q.delete();
    end else begin
      chk("done_drain1", WD'(done), '0);
      @(negedge clk);
      chk("done_drain2", WD'(done), '0);
      @(negedge clk);
      chk("done_rise", WD'(done), WD'(1));
      chk("all_writes", WD'(exp_q.size()), '0);
    end
  endtask
  initial begin
    ddr1_valid = 1; ddr2_valid = 1;
    repeat (2) @(negedge clk);
    chk("reset_done", WD'(done), WD'(1));
    chk("reset_readies", WD'({ddr1_ready, ddr2_ready}), '0);
    chk("reset_wr_en", WD'(buf_wr_en), '0);
    chk("reset_addr", WD'(buf_wr_addr), '0);
    chk("reset_data", buf_wr_data, '0);
    rst = 0; ddr1_valid = 0; ddr2_valid = 0;
    conf_shift = 4'd4;
    run_pass(0, 0, 1, 1, 1, 0, 9999, 0);
    run_pass(1, 0, 0, 0, 0, 0, 9999, 1);
    run_pass(0, 1, 3, 2, 1, 0, 9999, 1);
    run_pass(1, 0, 1, 3, 1, 1, 9999, 0);
    run_pass(0, 1, 2, 2, 3, 2, 9999, 0);
    run_pass(1, 0, 1, 1, 1, 0, 3, 0);
    run_pass(1, 0, 1, 1, 1, 0, 9999, 0);
    for (int t = 0; t < 4; t++)
      run_pass(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 3)), 2, 9999, 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
